pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised program-counter unit for the single-cycle/multi-cycle CPU datapath. It produces the fetch address and selects among sequential, conditional-branch, absolute-jump, register-jump, call and return targets. It contains an internal return-address stack (RAS) of configurable depth. It updates on the falling CLK edge, so fetch sees a stable address for the following rising-edge datapath phase.

Parameters:
ADDR_W, 32, address width in bits (>= JADDR_W+4)
IMM_W, 16, branch offset width (signed word offset)
JADDR_W, 26, absolute jump field width (word address)
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)
RESET_ADDR, 0, Address value loaded on reset (word aligned)
TRAP_VECTOR, 32'h0000_0080, target on misaligned register jump (optional feature only)

Ports:
CLK  in  1  clock; all state changes on negedge
Reset  in  1  reset, asynchronous, active-low
PCWre  in  1  update enable; 0 = stall, no state change (Address, RAS, flags hold)
PCSrc  in  3  next-PC mode: 0 SEQ, 1 BR, 2 J, 3 JR, 4 CALL, 5 RET, 6 CALLR, 7 reserved (acts as SEQ)
Cond  in  1  branch condition; used only in BR
Immediate  in  IMM_W  signed word offset for BR
JumpTarget  in  JADDR_W  word address for J/CALL
RegTarget  in  ADDR_W  byte address for JR/CALLR
RasClr  in  1  synchronous clear of RAS contents/count/flags (acts regardless of PCWre)
Address  out  ADDR_W  current PC (registered)
PCPlus4  out  ADDR_W  Address+4, combinational
RasEmpty  out  1  RAS count == 0
RasFull  out  1  RAS count == RAS_DEPTH
RasOvf  out  1  sticky: push occurred while full
RasUnf  out  1  sticky: pop occurred while empty
AlignTrap  out  1  one-cycle pulse, misaligned register target (tied 0 without feature)

Behaviour:
- Reset low (async): Address=RESET_ADDR; RAS count=0, top pointer=0; RasOvf=RasUnf=AlignTrap=0. RAS entry contents need not be cleared.
- All arithmetic is modulo 2^ADDR_W; carries beyond ADDR_W are discarded.
- Targets:
  - seq = Address+4
  - br = Address + 4 + (sign_extend(Immediate) << 2), with the shift applied to the extended offset only
  - j = {PCPlus4[ADDR_W-1:JADDR_W+2], JumpTarget, 2'b00}
  - r = {RegTarget[ADDR_W-1:2], 2'b00}
- On negedge CLK with PCWre=1:
  - SEQ/7: Address <= seq
  - BR: Address <= Cond ? br : seq
  - J: Address <= j
  - JR: Address <= r
  - CALL: push seq; Address <= j
  - CALLR: push seq; Address <= r
  - RET: pop; Address <= popped value. If RAS is empty: Address <= seq, RasUnf <= 1, count stays 0.
- Latency: the new Address is visible right after the update edge. PCPlus4 follows combinationally.
- RAS behaviour:
  - Circular buffer.
  - Push writes at top+1 (wrap mod RAS_DEPTH) and increments count.
  - Push while full overwrites the oldest entry, keeps count=RAS_DEPTH and sets RasOvf.
  - Pop reads at top, decrements top (wrap) and decrements count.
- RasOvf/RasUnf clear only on Reset or RasClr.
- RasClr=1 on an edge: count=0, flags cleared. A simultaneous push/pop in the same edge is discarded, but the Address update still follows PCSrc.
- PCWre=0: hold everything. AlignTrap goes 0. RasClr is still honoured.

Optional Feature:
- Macro PC_ALIGN_TRAP_EN.
- Defined: on JR/CALLR with RegTarget[1:0]!=0, Address <= TRAP_VECTOR, AlignTrap=1 for exactly one cycle, and no push occurs.
- Undefined: the low two bits are silently cleared as above and AlignTrap is constant 0.

Test Plan:
- Reset low mid-run with Address=0x40, RAS count 2 -> immediately Address=0, RasEmpty=1, flags 0; after release, SEQ x3 -> 4, 8, 0xC.
- Address=0x100, BR, Cond=1, Immediate=16'hFFFE -> 0x0FC; Cond=0 -> 0x104; Immediate=0x0003 -> 0x110.
- Address=0xF000_0010, J, JumpTarget=0x000_0040 -> 0xF000_0100; PCWre=0 for 3 edges -> stays 0xF000_0100.
- Address=0x20, CALL to 0x200; at 0x200 CALLR RegTarget=0x300; RET -> 0x204; RET -> 0x24; RET on empty -> 0x28 with RasUnf=1.
- RAS_DEPTH=4: 5 consecutive CALLs from 0x0,0x10,0x20,0x30,0x40 -> RasFull=1, RasOvf=1; 4 RETs return 0x44,0x34,0x24,0x14; RasClr -> RasEmpty=1, RasOvf=0.
- JR RegTarget=0x0000_0102: with PC_ALIGN_TRAP_EN -> Address=0x80, AlignTrap pulses 1 cycle, RAS unchanged; without it -> Address=0x100, AlignTrap=0.

Source files
------------

// File: rtl/pc_unit_if.sv
// Control and status bundle of the program-counter unit: next-PC selection inputs from the
// decoder, fetch address and return-address-stack status back out.
interface pc_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned JADDR_W = 26
);
  logic               PCWre;
  logic [2:0]         PCSrc;
  logic               Cond;
  logic [IMM_W-1:0]   Immediate;
  logic [JADDR_W-1:0] JumpTarget;
  logic [ADDR_W-1:0]  RegTarget;
  logic               RasClr;
  logic [ADDR_W-1:0]  Address;
  logic [ADDR_W-1:0]  PCPlus4;
  logic               RasEmpty;
  logic               RasFull;
  logic               RasOvf;
  logic               RasUnf;
  logic               AlignTrap;

  modport master (
    output PCWre, PCSrc, Cond, Immediate, JumpTarget, RegTarget, RasClr,
    input  Address, PCPlus4, RasEmpty, RasFull, RasOvf, RasUnf, AlignTrap
  );

  modport slave (
    input  PCWre, PCSrc, Cond, Immediate, JumpTarget, RegTarget, RasClr,
    output Address, PCPlus4, RasEmpty, RasFull, RasOvf, RasUnf, AlignTrap
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential/branch/jump/call/return selection and a circular
// return-address stack; updates on the falling clock edge. PC_ALIGN_TRAP_EN enables the
// misaligned register-jump trap.
module pc_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       IMM_W       = 16,
  parameter int unsigned       JADDR_W     = 26,
  parameter int unsigned       RAS_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'(32'h0000_0080)
) (
  input logic       CLK,
  input logic       Reset,
  pc_unit_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SrcSeq, SrcBr, SrcJ, SrcJr, SrcCall, SrcRet, SrcCallr, SrcRsvd
  } pc_src_e;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PtrW-1:0]   top_q, top_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              trap_q, trap_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] seq_tgt, br_tgt, j_tgt, r_tgt, imm_ext;
  logic [PtrW-1:0]   wr_ptr;
  logic              push_en, pop_en, ras_full, ras_empty, reg_misalign;
  pc_src_e           src;

  assign src       = pc_src_e'(bus.PCSrc);
  assign seq_tgt   = addr_q + ADDR_W'(4);
  assign imm_ext   = {{(ADDR_W-IMM_W){bus.Immediate[IMM_W-1]}}, bus.Immediate};
  assign br_tgt    = seq_tgt + (imm_ext << 2);
  assign j_tgt     = {seq_tgt[ADDR_W-1:JADDR_W+2], bus.JumpTarget, 2'b00};
  assign r_tgt     = {bus.RegTarget[ADDR_W-1:2], 2'b00};
  assign wr_ptr    = top_q + PtrW'(1);
  assign ras_full  = (cnt_q == FullCnt);
  assign ras_empty = (cnt_q == '0);

`ifdef PC_ALIGN_TRAP_EN
  assign reg_misalign = |bus.RegTarget[1:0];
`else
  logic unused_reg_lsbs;
  assign unused_reg_lsbs = ^bus.RegTarget[1:0];
  assign reg_misalign    = 1'b0;
`endif

  always_comb begin
    addr_d  = addr_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    trap_d  = 1'b0;
    push_en = 1'b0;
    pop_en  = 1'b0;

    if (bus.PCWre) begin
      case (src)
        SrcBr:   addr_d = bus.Cond ? br_tgt : seq_tgt;
        SrcJ:    addr_d = j_tgt;
        SrcCall: begin
          addr_d  = j_tgt;
          push_en = 1'b1;
        end
        SrcJr, SrcCallr: begin
          if (reg_misalign) begin
            addr_d = TRAP_VECTOR;
            trap_d = 1'b1;
          end else begin
            addr_d  = r_tgt;
            push_en = (src == SrcCallr);
          end
        end
        SrcRet: begin
          if (ras_empty) begin
            addr_d = seq_tgt;
            unf_d  = 1'b1;
          end else begin
            addr_d = ras_q[top_q];
            pop_en = 1'b1;
          end
        end
        default: addr_d = seq_tgt;
      endcase
    end

    // A clear wins over any stack movement requested on the same edge.
    if (bus.RasClr) begin
      push_en = 1'b0;
      pop_en  = 1'b0;
      top_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push_en) begin
      top_d = wr_ptr;
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CntW'(1);
    end else if (pop_en) begin
      top_d = top_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(negedge CLK or negedge Reset) begin
    if (!Reset) begin
      addr_q <= RESET_ADDR;
      top_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      trap_q <= trap_d;
    end
  end

  // Stack contents carry no reset; validity is tracked by cnt_q alone.
  always_ff @(negedge CLK) begin
    if (push_en) ras_q[wr_ptr] <= seq_tgt;
  end

  assign bus.Address   = addr_q;
  assign bus.PCPlus4   = seq_tgt;
  assign bus.RasEmpty  = ras_empty;
  assign bus.RasFull   = ras_full;
  assign bus.RasOvf    = ovf_q;
  assign bus.RasUnf    = unf_q;
  assign bus.AlignTrap = trap_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus queues expected PC/flags per falling-edge update,
// a monitor checks them on the following rising edge.
module tb_pc_unit;

  logic CLK;
  logic Reset;

  pc_unit_if #(.ADDR_W(32), .IMM_W(16), .JADDR_W(26)) bus ();

  pc_unit #(
    .ADDR_W     (32),
    .IMM_W      (16),
    .JADDR_W    (26),
    .RAS_DEPTH  (4),
    .RESET_ADDR (32'h0),
    .TRAP_VECTOR(32'h0000_0080)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, J = 3'd2, JR = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, CALLR = 3'd6, RSVD = 3'd7;

  // flags = {RasEmpty, RasFull, RasOvf, RasUnf, AlignTrap}
  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [4:0]  flags;
    bit          chk;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  initial CLK = 1'b1;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    exp_t       e;
    logic [4:0] got;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      got = {bus.RasEmpty, bus.RasFull, bus.RasOvf, bus.RasUnf, bus.AlignTrap};
      n_total++;
      if (bus.Address === e.addr) n_pass++;
      else $display("FAIL %s Address: got %h want %h", e.name, bus.Address, e.addr);
      n_total++;
      if (bus.PCPlus4 === e.addr + 32'd4) n_pass++;
      else $display("FAIL %s PCPlus4: got %h want %h", e.name, bus.PCPlus4, e.addr + 32'd4);
      if (e.chk) begin
        n_total++;
        if (got === e.flags) n_pass++;
        else $display("FAIL %s flags(E,F,O,U,T): got %b want %b", e.name, got, e.flags);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [31:0] a, input logic [4:0] f,
                            input bit chk);
    exp_t e;
    e.name  = nm;
    e.addr  = a;
    e.flags = f;
    e.chk   = chk;
    sb_q.push_back(e);
  endtask

  // Drive one update, queue its expectation, then move past the next rising edge.
  task automatic step(input string nm, input logic we, input logic [2:0] src,
                      input logic cond, input logic [15:0] imm, input logic [25:0] jt,
                      input logic [31:0] rt, input logic clr, input logic [31:0] a,
                      input logic [4:0] f, input bit chk);
    bus.PCWre      = we;
    bus.PCSrc      = src;
    bus.Cond       = cond;
    bus.Immediate  = imm;
    bus.JumpTarget = jt;
    bus.RegTarget  = rt;
    bus.RasClr     = clr;
    expect_now(nm, a, f, chk);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    bus.PCWre = 1'b0; bus.PCSrc = SEQ; bus.Cond = 1'b0; bus.Immediate = '0;
    bus.JumpTarget = '0; bus.RegTarget = '0; bus.RasClr = 1'b0;
    #1;
    expect_now("reset", 32'h0, 5'b10000, 1'b1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;

    // Build Address=0x40 with two stacked returns, then reset asynchronously.
    step("call_a", 1, CALL, 0, 16'h0, 26'h4,  32'h0, 0, 32'h10, 5'b00000, 1);
    step("call_b", 1, CALL, 0, 16'h0, 26'h10, 32'h0, 0, 32'h40, 5'b00000, 1);
    Reset = 1'b0;
    expect_now("async_reset", 32'h0, 5'b10000, 1'b1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    step("seq1", 1, SEQ, 0, 16'h0, 26'h0, 32'h0, 0, 32'h4, 5'b10000, 1);
    step("seq2", 1, SEQ, 0, 16'h0, 26'h0, 32'h0, 0, 32'h8, 5'b10000, 0);
    step("seq3", 1, SEQ, 0, 16'h0, 26'h0, 32'h0, 0, 32'hC, 5'b10000, 1);

    // Conditional branches from 0x100.
    step("j_100a",  1, J,  0, 16'h0,    26'h40, 32'h0, 0, 32'h100, 5'b10000, 0);
    step("br_back", 1, BR, 1, 16'hFFFE, 26'h0,  32'h0, 0, 32'h0FC, 5'b10000, 0);
    step("j_100b",  1, J,  0, 16'h0,    26'h40, 32'h0, 0, 32'h100, 5'b10000, 0);
    step("br_nt",   1, BR, 0, 16'hFFFE, 26'h0,  32'h0, 0, 32'h104, 5'b10000, 0);
    step("j_100c",  1, J,  0, 16'h0,    26'h40, 32'h0, 0, 32'h100, 5'b10000, 0);
    step("br_fwd",  1, BR, 1, 16'h0003, 26'h0,  32'h0, 0, 32'h110, 5'b10000, 0);

    // Jump keeps upper PC bits; stalls hold.
    step("jr_hi",  1, JR, 0, 16'h0, 26'h0,  32'hF000_0010, 0, 32'hF000_0010, 5'b10000, 0);
    step("j_hi",   1, J,  0, 16'h0, 26'h40, 32'h0,         0, 32'hF000_0100, 5'b10000, 0);
    step("stall1", 0, J,  1, 16'h0, 26'h0,  32'h0,         0, 32'hF000_0100, 5'b10000, 1);
    step("stall2", 0, RET, 1, 16'h0, 26'h0, 32'h0,         0, 32'hF000_0100, 5'b10000, 1);
    step("stall3", 0, CALL, 1, 16'h0, 26'h0, 32'h0,        0, 32'hF000_0100, 5'b10000, 1);

    // Address wrap and reserved encoding.
    step("jr_top",  1, JR,   0, 16'h0, 26'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 5'b10000, 0);
    step("seq_wrap", 1, SEQ, 0, 16'h0, 26'h0, 32'h0,         0, 32'h0,         5'b10000, 0);
    step("rsvd",    1, RSVD, 1, 16'h7, 26'h9, 32'h123,       0, 32'h4,         5'b10000, 0);

    // Nested call/return, then return on empty.
    step("jr_20",  1, JR,    0, 16'h0, 26'h0,  32'h20,  0, 32'h20,  5'b10000, 0);
    step("call_c", 1, CALL,  0, 16'h0, 26'h80, 32'h0,   0, 32'h200, 5'b00000, 1);
    step("callr",  1, CALLR, 0, 16'h0, 26'h0,  32'h300, 0, 32'h300, 5'b00000, 1);
    step("ret1",   1, RET,   0, 16'h0, 26'h0,  32'h0,   0, 32'h204, 5'b00000, 1);
    step("ret2",   1, RET,   0, 16'h0, 26'h0,  32'h0,   0, 32'h24,  5'b10000, 1);
    step("ret_unf", 1, RET,  0, 16'h0, 26'h0,  32'h0,   0, 32'h28,  5'b10010, 1);

    // Overflow: five calls into a four-deep stack.
    step("clr_seq", 1, SEQ,  0, 16'h0, 26'h0,  32'h0, 1, 32'h2C,  5'b10000, 1);
    step("jr_0",    1, JR,   0, 16'h0, 26'h0,  32'h0, 0, 32'h0,   5'b10000, 0);
    step("ovf_c1",  1, CALL, 0, 16'h0, 26'h4,  32'h0, 0, 32'h10,  5'b00000, 1);
    step("ovf_c2",  1, CALL, 0, 16'h0, 26'h8,  32'h0, 0, 32'h20,  5'b00000, 0);
    step("ovf_c3",  1, CALL, 0, 16'h0, 26'hC,  32'h0, 0, 32'h30,  5'b00000, 0);
    step("ovf_c4",  1, CALL, 0, 16'h0, 26'h10, 32'h0, 0, 32'h40,  5'b01000, 1);
    step("ovf_c5",  1, CALL, 0, 16'h0, 26'h40, 32'h0, 0, 32'h100, 5'b01100, 1);
    step("ovf_r1",  1, RET,  0, 16'h0, 26'h0,  32'h0, 0, 32'h44,  5'b00100, 1);
    step("ovf_r2",  1, RET,  0, 16'h0, 26'h0,  32'h0, 0, 32'h34,  5'b00100, 0);
    step("ovf_r3",  1, RET,  0, 16'h0, 26'h0,  32'h0, 0, 32'h24,  5'b00100, 0);
    step("ovf_r4",  1, RET,  0, 16'h0, 26'h0,  32'h0, 0, 32'h14,  5'b10100, 1);
    step("clr_stall", 0, SEQ, 0, 16'h0, 26'h0, 32'h0, 1, 32'h14,  5'b10000, 1);

    // Clear discards a same-edge push but the jump still happens.
    step("clr_call", 1, CALL, 0, 16'h0, 26'h40, 32'h0, 1, 32'h100, 5'b10000, 1);
    step("ret_e2",   1, RET,  0, 16'h0, 26'h0,  32'h0, 0, 32'h104, 5'b10010, 1);
    step("clr_seq2", 1, SEQ,  0, 16'h0, 26'h0,  32'h0, 1, 32'h108, 5'b10000, 1);

    // Misaligned register targets.
`ifdef PC_ALIGN_TRAP_EN
    step("jr_mis",    1, JR,    0, 16'h0, 26'h0, 32'h102, 0, 32'h80, 5'b10001, 1);
    step("after_mis", 1, SEQ,   0, 16'h0, 26'h0, 32'h0,   0, 32'h84, 5'b10000, 1);
    step("callr_mis", 1, CALLR, 0, 16'h0, 26'h0, 32'h203, 0, 32'h80, 5'b10001, 1);
    step("trap_stall", 0, SEQ,  0, 16'h0, 26'h0, 32'h0,   0, 32'h80, 5'b10000, 1);
`else
    step("jr_mis",    1, JR,    0, 16'h0, 26'h0, 32'h102, 0, 32'h100, 5'b10000, 1);
    step("after_mis", 1, SEQ,   0, 16'h0, 26'h0, 32'h0,   0, 32'h104, 5'b10000, 1);
    step("callr_mis", 1, CALLR, 0, 16'h0, 26'h0, 32'h203, 0, 32'h200, 5'b00000, 1);
    step("trap_stall", 0, SEQ,  0, 16'h0, 26'h0, 32'h0,   0, 32'h200, 5'b00000, 1);
`endif

    @(posedge CLK);
    #1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
